alu_scheduler: RTL
==================

Name: alu_scheduler

Overview:
- Round-robin scheduler that shares one combinational ALU between NUM_REQ requesters.
- Accepts one operation at a time over per-requester valid/ready and registers its operands.
- Drives the shared ALU from those registers and captures the ALU result.
- Returns the result, tagged with the requester id, over a single valid/ready response channel to the issuing unit.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_IN_WIDTH, 32, operand width; matches the ALU input width.
- OP_CODE_WIDTH, 4, ALU opcode width.
- DATA_OUT_WIDTH, 64, ALU result width.
- ID_WIDTH is derived as $clog2(NUM_REQ); it is a localparam and is not overridable.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  input  NUM_REQ*DATA_IN_WIDTH  packed operand A; requester i occupies slice [i*DATA_IN_WIDTH +: DATA_IN_WIDTH].
- req_b  input  NUM_REQ*DATA_IN_WIDTH  packed operand B; same packing as req_a.
- req_op  input  NUM_REQ*OP_CODE_WIDTH  packed opcodes; same packing scheme.
- alu_a  output  DATA_IN_WIDTH  to ALU scalar_a.
- alu_b  output  DATA_IN_WIDTH  to ALU scalar_b.
- alu_op  output  OP_CODE_WIDTH  to ALU op_code.
- alu_result  input  DATA_OUT_WIDTH  from ALU alu_out.
- resp_valid  output  1  response valid.
- resp_ready  input  1  response consumer ready.
- resp_data  output  DATA_OUT_WIDTH  captured ALU result.
- resp_id  output  ID_WIDTH  index of the requester that issued the operation.
- resp_div0  output  1  set when the operation was divide (4'b0011) with B == 0.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - state = IDLE, last_grant = NUM_REQ-1, so requester 0 wins first.
  - Operand, op, resp_data, resp_id and resp_div0 registers clear to 0; resp_valid = 0.
- alu_a, alu_b and alu_op are driven directly from the operand/op registers at all times, so they are 0 after reset.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Winner = first i with req_valid[i], searching from last_grant+1 and wrapping modulo NUM_REQ.
  - req_ready[winner] = 1 combinationally in this cycle only; all other req_ready bits = 0.
  - On that handshake: latch a, b, op and id; last_grant <= winner; go to EXEC.
  - No req_valid asserted: stay in IDLE; last_grant is unchanged.
- EXEC (1 cycle):
  - ALU sees the registered operands.
  - resp_data <= alu_result; resp_div0 <= (op == 4'b0011 && b == 0); resp_valid <= 1; go to RESP.
- RESP:
  - resp_valid = 1; resp_data, resp_id and resp_div0 stay stable until resp_ready.
  - On resp_ready: resp_valid <= 0, go to IDLE.
  - req_ready = 0 in EXEC and RESP.
- Latency: request handshake at cycle T gives resp_valid high from T+2. Minimum issue interval is 3 cycles.
- Requesters must hold valid and payload until ready; the scheduler does not check this.
- A requester that deasserts valid before being granted loses nothing; arbitration is re-evaluated every IDLE cycle.
- Fairness: with all NUM_REQ requesters continuously valid, grants cycle 0,1,2,...,NUM_REQ-1,0.
- rst_n asserted in EXEC or RESP: the in-flight operation is dropped with no response, and all state returns to reset values immediately.
- The scheduler never modifies alu_result; width and truncation follow the ALU.

Optional Feature:
- Macro: ALU_SCHED_BACK2BACK_EN.
- Defined:
  - In RESP, when resp_ready = 1 and some req_valid is set, arbitration runs in the same cycle.
  - The winner gets req_ready and its operands are latched; the FSM goes RESP -> EXEC directly.
  - Minimum issue interval becomes 2 cycles.
- Undefined: req_ready is 0 in RESP; behaviour is exactly as above.

Test Plan:
- Reset check: reset, then single request on req 2 with a=7, b=5, op=0000:
  - req_ready[2] is high in the accept cycle.
  - Two cycles later: resp_valid=1, resp_data=12, resp_id=2, resp_div0=0.
- All 4 requesters continuously valid, resp_ready=1, various ops:
  - Grant order 0,1,2,3,0,1.
  - Each response id and data matches its ALU op, e.g. req 1 op 0010 with a=6, b=9 gives 54.
- Divide by zero: op=0011, a=100, b=0:
  - resp_data=0, resp_div0=1.
  - A following request with a=100, b=4 gives 25 and resp_div0=0.
- Backpressure: hold resp_ready=0 for 5 cycles with a response pending:
  - resp_valid, resp_data and resp_id stay stable.
  - req_ready stays 0 even though req 3 is valid; req 3 is granted in the first IDLE cycle after release.
- Reset mid-operation: assert rst_n low during EXEC:
  - resp_valid stays 0, last_grant returns to 3, so the next grant goes to req 0.
  - alu_a, alu_b and alu_op read 0.
- With ALU_SCHED_BACK2BACK_EN and two requesters always valid, resp_ready=1:
  - Accepts occur every 2 cycles.
  - Without the macro, accepts occur every 3 cycles.

Source files
------------

// File: rtl/alu_scheduler.sv
// alu_scheduler: round-robin sharing of one combinational ALU among NUM_REQ requesters.
// Define ALU_SCHED_BACK2BACK_EN to let a new request be accepted in the response-release cycle.
module alu_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_IN_WIDTH  = 32,
  parameter int OP_CODE_WIDTH  = 4,
  parameter int DATA_OUT_WIDTH = 64,
  localparam int ID_WIDTH      = $clog2(NUM_REQ)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ*DATA_IN_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*DATA_IN_WIDTH-1:0]   req_b,
  input  logic [NUM_REQ*OP_CODE_WIDTH-1:0]   req_op,
  output logic [DATA_IN_WIDTH-1:0]           alu_a,
  output logic [DATA_IN_WIDTH-1:0]           alu_b,
  output logic [OP_CODE_WIDTH-1:0]           alu_op,
  input  logic [DATA_OUT_WIDTH-1:0]          alu_result,
  output logic                               resp_valid,
  input  logic                               resp_ready,
  output logic [DATA_OUT_WIDTH-1:0]          resp_data,
  output logic [ID_WIDTH-1:0]                resp_id,
  output logic                               resp_div0
);
`ifdef ALU_SCHED_BACK2BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t                    r_state, w_next;
  logic [ID_WIDTH-1:0]       r_last, r_id, w_win, w_idx;
  logic                      w_found, w_arb, w_acc;
  logic [DATA_IN_WIDTH-1:0]  r_a, r_b;
  logic [OP_CODE_WIDTH-1:0]  r_op;
  logic [DATA_OUT_WIDTH-1:0] r_data;
  logic                      r_div0, r_valid;
  // search starts just after the last grant so every requester gets its turn
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = ID_WIDTH'((int'(r_last) + k) % NUM_REQ);
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end
  assign w_arb     = (r_state == IDLE) || (B2B && r_state == RESP && resp_ready);
  assign w_acc     = w_arb && w_found;
  assign req_ready = w_acc ? NUM_REQ'(1) << w_win : '0;
  always_comb begin
    w_next = r_state;
    w_next = w_acc ? EXEC :
             (r_state == EXEC) ? RESP :
             (r_state == RESP && resp_ready) ? IDLE : r_state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_last  <= ID_WIDTH'(NUM_REQ - 1);
      r_id    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_data  <= '0;
      r_div0  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_acc) begin
        r_last <= w_win;
        r_id   <= w_win;
        r_a    <= req_a[int'(w_win)*DATA_IN_WIDTH +: DATA_IN_WIDTH];
        r_b    <= req_b[int'(w_win)*DATA_IN_WIDTH +: DATA_IN_WIDTH];
        r_op   <= req_op[int'(w_win)*OP_CODE_WIDTH +: OP_CODE_WIDTH];
      end
      if (r_state == EXEC) begin
        r_data  <= alu_result;
        r_div0  <= (r_op == OP_CODE_WIDTH'(3)) && (r_b == '0);
        r_valid <= 1'b1;
      end else if (r_state == RESP && resp_ready) begin
        r_valid <= 1'b0;
      end
    end
  end
  assign alu_a      = r_a;
  assign alu_b      = r_b;
  assign alu_op     = r_op;
  assign resp_valid = r_valid;
  assign resp_data  = r_data;
  assign resp_id    = r_id;
  assign resp_div0  = r_div0;
endmodule
